// File: rtl/half_duplex_bus_port_pkg.sv
// Purpose: shared types, constants and the parity helper for the half-duplex bus port.
// Latency: n/a (declarations only).
// Backpressure: n/a. BUS_PARITY_EN adds one even-parity bit above the data bits.
package half_duplex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // Width of the turnaround counter; holds TA_CYCLES up to 15.
    localparam int TA_W = 4;

`ifdef BUS_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Even parity: the returned bit makes the total number of ones even.
    // Data wider than 32 bits is not supported by this helper.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/half_duplex_bus_port_if.sv
// Purpose: local-side handshake and bus-control signals of the half-duplex port.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready handshake; rx_valid is a pulse with no ready.
// Ports: master = the port itself, slave = the local user / peer model.
interface half_duplex_bus_port_if #(
    parameter int W = 8
);
    import half_duplex_pkg::*;

    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         bus_oe;
    logic         bus_stb_o;
    logic         bus_stb_i;
    logic         busy;
    logic         par_err;

    modport master (
        input  tx_data, tx_valid, bus_stb_i,
        output tx_ready, rx_data, rx_valid, bus_oe, bus_stb_o, busy, par_err
    );

    modport slave (
        output tx_data, tx_valid, bus_stb_i,
        input  tx_ready, rx_data, rx_valid, bus_oe, bus_stb_o, busy, par_err
    );

endinterface

// File: rtl/half_duplex_bus_port_ta_cnt.sv
// Purpose: turnaround counter (load to TA_CYCLES, saturating decrement, zero flag).
// Latency: load/decrement visible one cycle after the request.
// Backpressure: none; load has priority over decrement, reset loads.
// Ports: clk, rst, i_load, i_dec in; o_cnt, o_zero out.
module bus_turnaround_cnt
    import half_duplex_pkg::*;
#(
    parameter int TA_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_dec,
    output logic [TA_W-1:0] o_cnt,
    output logic            o_zero
);

    localparam logic [TA_W-1:0] LOAD_VAL = TA_W'(TA_CYCLES);

    logic [TA_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/half_duplex_bus_port.sv
// Purpose: one end of a shared bidirectional bus; drives local tx words, captures peer strobes.
// Latency: tx accept -> bus_stb_o 1 cycle; peer strobe -> rx_valid 1 cycle.
// Backpressure: tx_ready low until TA_CYCLES quiet cycles after any bus activity; receive wins ties.
// Ports: clk, rst (sync, active high), io_port (handshake interface), bus_io (W bits, W+1 with
//        BUS_PARITY_EN where bit W is even parity of the data; par_err is tied 0 without it).
module half_duplex_bus_port
    import half_duplex_pkg::*;
#(
    parameter  int W         = 8,
    parameter  int TA_CYCLES = 2,
    localparam int BW        = W + PAR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    half_duplex_bus_port_if.master io_port,
    inout  wire [BW-1:0]           bus_io
);

    state_t          r_state;
    logic [W-1:0]    r_tx_word;
    logic            r_bus_oe;
    logic [W-1:0]    r_rx_data;
    logic            r_rx_valid;

    logic [TA_W-1:0] w_cnt;
    logic            w_cnt_zero;
    logic            w_capture;
    logic            w_tx_rdy;
    logic            w_accept;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic [BW-1:0]   w_drive_word;

    // A strobe while we drive is a peer protocol violation and is dropped.
    assign w_capture = !rst && io_port.bus_stb_i && (r_state != DRIVE);

    // Streaming continues straight from DRIVE; from IDLE the bus must have been quiet.
    assign w_tx_rdy  = !rst && ((r_state == DRIVE) ||
                                ((r_state == IDLE) && w_cnt_zero && !io_port.bus_stb_i));
    assign w_accept  = w_tx_rdy && io_port.tx_valid;

    // Every peer strobe and the end of a drive burst restart the quiet window.
    assign w_cnt_load = w_capture || ((r_state == DRIVE) && !w_accept);
    assign w_cnt_dec  = (r_state != DRIVE);

    bus_turnaround_cnt #(
        .TA_CYCLES (TA_CYCLES)
    ) u_ta_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_cnt_load),
        .i_dec  (w_cnt_dec),
        .o_cnt  (w_cnt),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_bus_oe   <= 1'b0;
            r_tx_word  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else begin
            r_rx_valid <= w_capture;
            if (w_capture) begin
                r_rx_data <= bus_io[W-1:0];
            end
            if (w_accept) begin
                r_tx_word <= io_port.tx_data;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= DRIVE;
                        r_bus_oe <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (!w_accept) begin
                        r_state  <= TURN;
                        r_bus_oe <= 1'b0;
                    end
                end
                TURN: begin
                    // Leave on the 1 -> 0 step unless a strobe just reloaded the window.
                    if (!w_capture && (w_cnt <= TA_W'(1))) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_bus_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_PARITY_EN
    logic r_par_err;
    logic w_rx_par_bad;

    assign w_drive_word = {even_parity(32'(r_tx_word)), r_tx_word};
    assign w_rx_par_bad = bus_io[W] != even_parity(32'(bus_io[W-1:0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_capture && w_rx_par_bad) begin
            r_par_err <= 1'b1;
        end
    end

    assign io_port.par_err = r_par_err;
`else
    assign w_drive_word    = r_tx_word;
    assign io_port.par_err = 1'b0;
`endif

    assign bus_io = r_bus_oe ? w_drive_word : {BW{1'bz}};

    assign io_port.tx_ready  = w_tx_rdy;
    assign io_port.rx_data   = r_rx_data;
    assign io_port.rx_valid  = r_rx_valid;
    assign io_port.bus_oe    = r_bus_oe;
    assign io_port.bus_stb_o = r_bus_oe;
    assign io_port.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_half_duplex_bus_port.sv
// Purpose: scoreboard bench for half_duplex_bus_port against a quiet-window reference model.
// Latency: expects bus_stb_o and rx_valid one cycle after accept/strobe.
// Backpressure: tx_ready predicted from cycles elapsed since the last bus activity.
module tb_half_duplex_bus_port;
    import half_duplex_pkg::*;

    localparam int W  = 8;
    localparam int TA = 2;
    localparam int BW = W + PAR_BITS;

    typedef struct {
        int            due;
        logic [BW-1:0] word;
        logic          par;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    half_duplex_bus_port_if #(.W(W)) port_if ();

    wire  [BW-1:0] bus_io;
    logic          peer_oe;
    logic [BW-1:0] peer_word;
    assign bus_io = peer_oe ? peer_word : {BW{1'bz}};

    half_duplex_bus_port #(
        .W         (W),
        .TA_CYCLES (TA)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_port (port_if),
        .bus_io  (bus_io)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the bus is free for a new local drive once more than TA
    // cycles have passed since the last cycle with any activity (own drive,
    // peer strobe, or reset); a drive cycle lets the next word follow at once.
    int   m_last_act = 0;
    int   m_arm_cyc  = 0;
    bit   m_armed    = 1'b0;
    bit   m_acc_prev = 1'b0;
    bit   m_turn     = 1'b0;
    bit   m_par      = 1'b0;
    bit   m_accept   = 1'b0;
    exp_t tx_q[$];
    exp_t rx_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic tv, input logic [W-1:0] td,
                        input logic stb, input logic [BW-1:0] pw);
        bit            exp_ready;
        bit            exp_busy;
        bit            cap;
        bit            bad;
        int            gap;
        logic [BW-1:0] tw;
        @(posedge clk);
        #1;
        rst               = r;
        port_if.tx_valid  = tv;
        port_if.tx_data   = td;
        port_if.bus_stb_i = stb;
        peer_oe           = stb && !m_acc_prev;
        peer_word         = pw;
        @(negedge clk);
        gap = cyc - m_last_act;
        if (m_turn && gap > TA) m_turn = 1'b0;
        exp_ready = !r && (m_acc_prev || (!stb && gap > TA));
        exp_busy  = m_acc_prev || m_turn;
        if (m_armed) begin
            chk("bus_oe", 32'(port_if.bus_oe), 32'(m_acc_prev));
            chk("busy", 32'(port_if.busy), 32'(exp_busy));
            if (tv) chk("tx_ready", 32'(port_if.tx_ready), 32'(exp_ready));
        end
        m_accept = !r && tv && exp_ready;
        cap      = !r && stb && !m_acc_prev;
        if (m_accept) begin
            tw = BW'(td);
`ifdef BUS_PARITY_EN
            tw[W] = ^td;
`endif
            tx_q.push_back('{due: cyc + 1, word: tw, par: 1'b0});
        end
        if (cap) begin
            bad = 1'b0;
`ifdef BUS_PARITY_EN
            bad = pw[W] != (^pw[W-1:0]);
`endif
            m_par = m_par | bad;
            rx_q.push_back('{due: cyc + 1, word: pw, par: m_par});
        end
        if (r) begin
            if (!m_armed) m_arm_cyc = cyc + 1;
            m_armed    = 1'b1;
            m_last_act = cyc;
            m_turn     = 1'b0;
            m_par      = 1'b0;
            m_acc_prev = 1'b0;
        end else begin
            if (m_acc_prev) begin
                m_last_act = cyc;
                m_turn     = 1'b1;
            end else if (stb) begin
                m_last_act = cyc;
            end
            m_acc_prev = m_accept;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic send(input logic [W-1:0] d);
        int n = 0;
        do begin
            step(1'b0, 1'b1, d, 1'b0, '0);
            n++;
        end while (!m_accept && n < 40);
        if (!m_accept) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, n);
        end
    endtask

    // Monitor: whenever the DUT presents a bus word or an rx pulse, pop and compare.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_tx;
        bit   exp_rx;
        if (m_armed && cyc >= m_arm_cyc) begin
            exp_tx = (tx_q.size() != 0) && (tx_q[0].due == cyc);
            chk("bus_stb_o", 32'(port_if.bus_stb_o), 32'(exp_tx));
            if (exp_tx) begin
                e = tx_q.pop_front();
                chk("bus_io_word", 32'(bus_io), 32'(e.word));
            end
            exp_rx = (rx_q.size() != 0) && (rx_q[0].due == cyc);
            chk("rx_valid", 32'(port_if.rx_valid), 32'(exp_rx));
            if (exp_rx) begin
                e = rx_q.pop_front();
                chk("rx_data", 32'(port_if.rx_data), 32'(e.word[W-1:0]));
                chk("par_err", 32'(port_if.par_err), 32'(e.par));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        port_if.tx_valid  = 1'b0;
        port_if.tx_data   = '0;
        port_if.bus_stb_i = 1'b0;
        peer_oe           = 1'b0;
        peer_word         = '0;

        // Reset held two cycles with tx_valid asserted.
        step(1'b1, 1'b1, 8'hA5, 1'b0, '0);
        step(1'b1, 1'b1, 8'hA5, 1'b0, '0);
        step(1'b0, 1'b1, 8'hA5, 1'b0, '0);
        chk("rst_rx_data", 32'(port_if.rx_data), 32'h0);
        chk("rst_rx_valid", 32'(port_if.rx_valid), 32'h0);
        chk("rst_par_err", 32'(port_if.par_err), 32'h0);
        chk("rst_bus_stb_o", 32'(port_if.bus_stb_o), 32'h0);

        // Single word, then the turnaround.
        send(8'hA5);
        idle(4);

        // Burst streams without gaps.
        send(8'h01);
        send(8'h02);
        send(8'h03);
        idle(4);

        // Peer strobe wins over a pending transmit.
        step(1'b0, 1'b1, 8'h77, 1'b1, BW'(8'h3C));
        send(8'h77);
        idle(4);

        // Peer strobe during our drive is ignored.
        send(8'hC3);
        step(1'b0, 1'b0, '0, 1'b1, '0);
        idle(4);

        // Reset while driving releases the bus.
        send(8'h5A);
        step(1'b1, 1'b0, '0, 1'b0, '0);
        idle(4);

`ifdef BUS_PARITY_EN
        step(1'b0, 1'b0, '0, 1'b1, 9'h103);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b1, 9'h003);
        idle(2);
        chk("par_err_sticky", 32'(port_if.par_err), 32'h1);
`endif

        // Randomised traffic in both directions.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)),
                 W'($urandom),
                 ($urandom_range(0, 5) == 0),
                 BW'($urandom));
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/half_duplex_bus_port.md
Name: half_duplex_bus_port

Overview:
- Bus-side counterpart of the tristate buffer: owns one end of a shared W-bit bidirectional bus.
- Drives the bus (output enable high) to transmit words from a local valid/ready source.
- Releases the bus to high-Z to receive words that the peer strobes onto it.
- Enforces turnaround gaps so that the two ends never drive the bus at the same time.

Parameters:
- W, 8, data width of the shared bus.
- TA_CYCLES, 2, minimum idle (high-Z) cycles between any drive and the opposite direction; range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  W  word to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  word accepted this cycle when tx_valid && tx_ready.
- rx_data  output  W  last received word.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- bus_io  inout  W(+1 with parity)  shared bus; driven only when bus_oe=1, else 'bz.
- bus_oe  output  1  registered output enable for bus_io.
- bus_stb_o  output  1  this end is presenting a valid word on bus_io.
- bus_stb_i  input  1  peer is presenting a valid word on bus_io.
- busy  output  1  state != IDLE.
- par_err  output  1  sticky receive-parity error (parity build only; tied 0 otherwise).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE, bus_oe=0, bus_io=Z, bus_stb_o=0.
  - tx_ready=0, rx_valid=0, rx_data=0, par_err=0.
  - Turnaround counter loaded with TA_CYCLES, so the first drive after reset waits TA_CYCLES cycles.
  - Reset mid-transfer releases the bus on the same edge.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - bus_oe=0.
  - If bus_stb_i=1: capture bus_io into rx_data and pulse rx_valid on the next cycle (latency 1); reload the turnaround counter.
  - Else, if tx_valid=1 and the counter is 0: tx_ready=1 (combinational from state/counter); on accept, register tx_data, go to DRIVE.
  - Receive has priority: when bus_stb_i and tx_valid arrive in the same cycle, the receive is taken and tx_ready stays 0.
- DRIVE:
  - bus_oe=1, bus_stb_o=1, bus_io = registered word. Exactly one cycle per word.
  - If tx_valid=1 on the DRIVE cycle, tx_ready=1 and back-to-back words stream without a gap; no turnaround is needed within the same direction.
  - Otherwise go to TURN with the counter reloaded to TA_CYCLES.
  - If bus_stb_i=1 while in DRIVE, that is a protocol violation: the peer's word is ignored and no rx_valid is produced.
- TURN:
  - bus_oe=0, bus_stb_o=0; the counter decrements each cycle.
  - At 1 -> 0, go to IDLE.
  - bus_stb_i during TURN is still captured (the peer is allowed to drive).
- Counter:
  - In IDLE it decrements to 0 and saturates there.
  - It reloads on every bus_stb_i, so a drive requires TA_CYCLES quiet cycles after the peer's last strobe.
- Latency: tx accept -> bus_stb_o = 1 cycle. Peer strobe -> rx_valid = 1 cycle.

Optional Feature:
- Macro BUS_PARITY_EN.
- When defined:
  - bus_io is W+1 bits; bit W carries even parity of the data, driven in DRIVE.
  - On receive, a parity mismatch sets par_err (sticky until rst); rx_valid still pulses.
- When undefined:
  - bus_io is W bits and par_err is constant 0.

Decomposition:
- Package half_duplex_pkg:
  - state enum {IDLE, DRIVE, TURN} in 2 bits.
  - TA_W=4 counter width constant.
  - Parity function.
- One natural sub-module, bus_turnaround_cnt: load/decrement/zero flag, reusable at the peer end.

Test Plan:
- Reset then idle: hold rst 2 cycles with tx_valid=1 -> bus_oe=0, tx_ready=0 for TA_CYCLES=2 cycles after rst drops, then tx_ready=1.
- Single transmit 8'hA5 -> bus_stb_o=1 and bus_io=8'hA5 one cycle after accept; then bus_oe=0 for exactly 2 TURN cycles; bus_io reads Z.
- Burst of 3 words 8'h01, 8'h02, 8'h03 with tx_valid held -> 3 consecutive DRIVE cycles with no gap, then a single TURN of 2 cycles.
- Peer drives 8'h3C with bus_stb_i=1 in IDLE while tx_valid=1 -> rx_valid pulse with rx_data=8'h3C next cycle; tx_ready stays 0 until 2 quiet cycles pass.
- rst asserted during DRIVE -> bus_oe=0 and bus_io=Z at the following edge; state IDLE; no rx_valid.
- BUS_PARITY_EN: peer sends 9'h1_03 (bad parity) -> rx_valid pulses and par_err=1 and stays 1; a later 9'h0_03 leaves par_err=1.
